// File: rtl/maze_pkg.sv
// Shared maze definitions: default geometry, built-in map contents and the loader state enum.
package maze_pkg;

    localparam int MAZE_WIDTH    = 8;
    localparam int MAZE_HEIGHT   = 8;
    localparam int MAZE_NUM_MAPS = 2;

    // Row 0 sits in the top byte; within a row bit 7 is column 0 and 1 means open.
    localparam logic [63:0] MAP0_ROWS = 64'hFF81_BDA5_A5BD_81FF;
    localparam logic [63:0] MAP1_ROWS = 64'h0FFC_27EA_8E92_B6E4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    function automatic logic [7:0] map_src_row(input int map_idx, input int row_idx);
        logic [63:0] rows;
        case (map_idx)
            0:       rows = MAP0_ROWS;
            1:       rows = MAP1_ROWS;
            default: rows = '0;
        endcase
        if (row_idx < 0 || row_idx > 7) begin
            return 8'h00;
        end
        rows = rows >> (8 * (7 - row_idx));
        return rows[7:0];
    endfunction

endpackage

// File: rtl/maze_map_store_if.sv
// Request/response bundle between the maze store and its clients.
// The cell edit signals exist only when MAZE_EDIT_EN is defined.
interface maze_map_store_if
    import maze_pkg::*;
#(
    parameter int WIDTH    = MAZE_WIDTH,
    parameter int HEIGHT   = MAZE_HEIGHT,
    parameter int NUM_MAPS = MAZE_NUM_MAPS
);
    localparam int MW = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    logic          load_req;
    logic [MW-1:0] load_sel;
    logic          load_err;
    logic          busy;

    logic          q_valid;
    logic [XW-1:0] q_x;
    logic [YW-1:0] q_y;
    logic          r_valid;
    logic          r_open;
    logic          r_oob;

    logic             row_req;
    logic [YW-1:0]    row_y;
    logic             row_valid;
    logic [WIDTH-1:0] row_data;

`ifdef MAZE_EDIT_EN
    logic          e_valid;
    logic [XW-1:0] e_x;
    logic [YW-1:0] e_y;
    logic          e_open;
`endif

    modport master (
`ifdef MAZE_EDIT_EN
        output e_valid, e_x, e_y, e_open,
`endif
        output load_req, load_sel, q_valid, q_x, q_y, row_req, row_y,
        input  load_err, busy, r_valid, r_open, r_oob, row_valid, row_data
    );

    modport slave (
`ifdef MAZE_EDIT_EN
        input  e_valid, e_x, e_y, e_open,
`endif
        input  load_req, load_sel, q_valid, q_x, q_y, row_req, row_y,
        output load_err, busy, r_valid, r_open, r_oob, row_valid, row_data
    );

endinterface

// File: rtl/maze_map_rom.sv
// Registered map ROM: one WIDTH-bit row per read, one cycle after en is sampled high.
module maze_map_rom
    import maze_pkg::*;
#(
    parameter int WIDTH = MAZE_WIDTH,
    parameter int MW    = 1,
    parameter int YW    = 3
) (
    input  logic             clk,
    input  logic             en,
    input  logic [MW-1:0]    map_sel,
    input  logic [YW-1:0]    addr,
    output logic [WIDTH-1:0] data
);

    // Stored maps are 8 columns wide; narrower mazes keep the leftmost columns, wider ones pad closed.
    function automatic logic [WIDTH-1:0] fit_row(input logic [7:0] src);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int x = 0; x < WIDTH; x++) begin
            if (x < 8) begin
                r[WIDTH-1-x] = src[3'(7 - x)];
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (en) begin
            data <= fit_row(map_src_row(int'(map_sel), int'(addr)));
        end
    end

endmodule

// File: rtl/maze_map_store.sv
// Active maze storage: loads maps row by row from ROM and answers cell and row reads.
// Define MAZE_EDIT_EN to add the single-cell edit port.
module maze_map_store
    import maze_pkg::*;
#(
    parameter int WIDTH    = MAZE_WIDTH,
    parameter int HEIGHT   = MAZE_HEIGHT,
    parameter int NUM_MAPS = MAZE_NUM_MAPS
) (
    input logic             clk,
    input logic             rst,
    maze_map_store_if.slave bus
);
    localparam int MW = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    state_t           state;
    state_t           next_state;
    logic [YW-1:0]    row_cnt;
    logic [YW-1:0]    wr_row;
    logic [MW-1:0]    map_q;
    logic             wr_pend;
    logic             busy;
    logic             rom_en;
    logic             load_bad;
    logic             load_ok;
    logic             q_ok;
    logic             q_oob;
    logic             q_bit;
    logic             row_ok;
    logic             row_in;
    logic [WIDTH-1:0] q_row;
    logic [WIDTH-1:0] rom_data;
    logic [WIDTH-1:0] cells [HEIGHT];

    assign load_bad = int'(bus.load_sel) >= NUM_MAPS;
    assign load_ok  = (state == IDLE) && bus.load_req && !load_bad;
    assign bus.busy = busy;

    maze_map_rom #(
        .WIDTH (WIDTH),
        .MW    (MW),
        .YW    (YW)
    ) u_rom (
        .clk     (clk),
        .en      (rom_en),
        .map_sel (map_q),
        .addr    (row_cnt),
        .data    (rom_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load_ok) next_state = LOAD;
            LOAD:    if (row_cnt == YW'(HEIGHT - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        rom_en = (state == LOAD);
    end

    // ROM output lags its address by a cycle, so the write row trails row_cnt by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt      <= '0;
            map_q        <= '0;
            wr_pend      <= 1'b0;
            wr_row       <= '0;
            bus.load_err <= 1'b0;
        end else begin
            wr_pend      <= rom_en;
            wr_row       <= row_cnt;
            bus.load_err <= (state == IDLE) && bus.load_req && load_bad;
            if (load_ok) begin
                map_q   <= bus.load_sel;
                row_cnt <= '0;
            end else if (rom_en) begin
                row_cnt <= row_cnt + 1'b1;
            end
        end
    end

`ifdef MAZE_EDIT_EN
    logic e_ok;
    assign e_ok = bus.e_valid && !busy && (int'(bus.e_x) < WIDTH) && (int'(bus.e_y) < HEIGHT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int y = 0; y < HEIGHT; y++) begin
                cells[y] <= '0;
            end
        end else if (wr_pend) begin
            cells[wr_row] <= rom_data;
`ifdef MAZE_EDIT_EN
        end else if (e_ok) begin
            cells[bus.e_y][XW'(WIDTH - 1) - bus.e_x] <= bus.e_open;
`endif
        end
    end

    always_comb begin
        q_ok   = bus.q_valid && !busy;
        q_oob  = (int'(bus.q_x) >= WIDTH) || (int'(bus.q_y) >= HEIGHT);
        q_row  = cells[bus.q_y];
        q_bit  = q_row[XW'(WIDTH - 1) - bus.q_x];
        row_ok = bus.row_req && !busy;
        row_in = int'(bus.row_y) < HEIGHT;
    end

    // Response fields are zeroed whenever their strobe is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.r_valid   <= 1'b0;
            bus.r_open    <= 1'b0;
            bus.r_oob     <= 1'b0;
            bus.row_valid <= 1'b0;
            bus.row_data  <= '0;
        end else begin
            bus.r_valid   <= q_ok;
            bus.r_open    <= q_ok && !q_oob && q_bit;
            bus.r_oob     <= q_ok && q_oob;
            bus.row_valid <= row_ok;
            bus.row_data  <= (row_ok && row_in) ? cells[bus.row_y] : '0;
        end
    end

endmodule
